pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_if.sv | 37 +++
 rtl/pipe_adder.sv | 121 ++++++++++++
 tb/tb_pipe_adder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder. The optional saturate
// input exists only when PIPE_ADDER_SAT_EN is defined.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             c_in;
  logic             sub;
`ifdef PIPE_ADDER_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
`ifdef PIPE_ADDER_SAT_EN
    output sat,
`endif
    output in_valid, X, Y, c_in, sub, out_ready,
    input  in_ready, out_valid, Z, c_out, ovf, zero
  );

  modport slave (
`ifdef PIPE_ADDER_SAT_EN
    input  sat,
`endif
    input  in_valid, X, Y, c_in, sub, out_ready,
    output in_ready, out_valid, Z, c_out, ovf, zero
  );
endinterface

// File: rtl/pipe_adder.sv
// Segmented pipelined adder/subtractor, SEG bits per stage, valid/ready on both ends.
// Optional output saturation is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic         clk,
  input  logic         rst,
  pipe_adder_if.slave  bus
);
  localparam int NSTG = (SEG > 0) ? (WIDTH / SEG) : 1;

  if ((SEG <= 0) || (WIDTH <= 0) || ((WIDTH % ((SEG > 0) ? SEG : 1)) != 0)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a positive multiple of SEG");
  end

  logic             adv;
  logic             sat_in;

  logic [NSTG-1:0]  v_q;
  logic [NSTG-1:0]  c_q;
  logic             s_q   [NSTG];
  logic [WIDTH-1:0] x_q   [NSTG];
  logic [WIDTH-1:0] y_q   [NSTG];
  logic [WIDTH-1:0] z_q   [NSTG];
  logic             ovf_q;
  logic             zero_q;

  logic [NSTG-1:0]  v_src;
  logic [NSTG-1:0]  c_src;
  logic [NSTG-1:0]  c_nxt;
  logic             s_src [NSTG];
  logic [WIDTH-1:0] x_src [NSTG];
  logic [WIDTH-1:0] y_src [NSTG];
  logic [WIDTH-1:0] z_src [NSTG];
  logic [WIDTH-1:0] z_nxt [NSTG];
  logic [SEG:0]     seg_sum;
  logic             x_sign;
  logic             y_sign;
  logic             ovf_nxt;
  logic             zero_nxt;
  logic [WIDTH-1:0] z_fin;

`ifdef PIPE_ADDER_SAT_EN
  assign sat_in = bus.sat;
`else
  assign sat_in = 1'b0;
`endif

  assign adv           = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[NSTG-1];
  assign bus.Z         = z_q[NSTG-1];
  assign bus.c_out     = c_q[NSTG-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  always_comb begin
    // Subtract is X + ~Y + ~c_in, so c_in acts as a borrow.
    v_src[0] = bus.in_valid;
    x_src[0] = bus.X;
    y_src[0] = bus.sub ? ~bus.Y : bus.Y;
    c_src[0] = bus.sub ? ~bus.c_in : bus.c_in;
    s_src[0] = sat_in;
    z_src[0] = '0;
    for (int k = 1; k < NSTG; k++) begin
      v_src[k] = v_q[k-1];
      x_src[k] = x_q[k-1];
      y_src[k] = y_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
      z_src[k] = z_q[k-1];
    end

    seg_sum = '0;
    for (int k = 0; k < NSTG; k++) begin
      seg_sum  = {1'b0, x_src[k][k*SEG +: SEG]} + {1'b0, y_src[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_src[k]};
      z_nxt[k] = z_src[k];
      z_nxt[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      c_nxt[k] = seg_sum[SEG];
    end

    x_sign  = x_src[NSTG-1][WIDTH-1];
    y_sign  = y_src[NSTG-1][WIDTH-1];
    ovf_nxt = (x_sign == y_sign) && (z_nxt[NSTG-1][WIDTH-1] != x_sign);
    z_fin   = z_nxt[NSTG-1];
    if (s_src[NSTG-1] && ovf_nxt) begin
      z_fin = x_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_nxt = (z_fin == '0);
  end

  // Whole pipeline moves as one shift register; a stall freezes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        s_q[k] <= 1'b0;
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_src;
      c_q <= c_nxt;
      for (int k = 0; k < NSTG; k++) begin
        s_q[k] <= s_src[k];
        x_q[k] <= x_src[k];
        y_q[k] <= y_src[k];
        z_q[k] <= z_nxt[k];
      end
      z_q[NSTG-1] <= z_fin;
      ovf_q       <= ovf_nxt;
      zero_q      <= zero_nxt;
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed vectors with hand-computed results,
// an independent monitor checks results, in_ready and stall stability.
module tb_pipe_adder;
  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int NSTG  = WIDTH / SEG;
  localparam int NV    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(WIDTH)) bus_if ();

  pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
    logic        sat;
    logic [31:0] zw;
    logic        c;
    logic        ovf;
    logic        zero_w;
    logic [31:0] zs;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic        c;
    logic        ovf;
    logic        zero;
  } res_t;

  vec_t vt [NV];
  res_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  bit   holding = 0;
  res_t held;
  bit   stream_done = 0;

  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic cin,
                              input logic sub, input logic sat, input logic [31:0] zw,
                              input logic c, input logic ovf, input logic zero_w,
                              input logic [31:0] zs);
    vec_t v;
    v.x = x; v.y = y; v.cin = cin; v.sub = sub; v.sat = sat;
    v.zw = zw; v.c = c; v.ovf = ovf; v.zero_w = zero_w; v.zs = zs;
    return v;
  endfunction

  function automatic res_t expect_of(input int i);
    res_t r;
    r.z = vt[i].zw; r.c = vt[i].c; r.ovf = vt[i].ovf; r.zero = vt[i].zero_w;
`ifdef PIPE_ADDER_SAT_EN
    if (vt[i].sat && vt[i].ovf) begin
      r.z    = vt[i].zs;
      r.zero = 1'b0;
    end
`endif
    return r;
  endfunction

  task automatic issue(input int i);
    bus_if.X        = vt[i].x;
    bus_if.Y        = vt[i].y;
    bus_if.c_in     = vt[i].cin;
    bus_if.sub      = vt[i].sub;
`ifdef PIPE_ADDER_SAT_EN
    bus_if.sat      = vt[i].sat;
`endif
    bus_if.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        exp_q.push_back(expect_of(i));
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL issue_timeout vector %0d: in_ready stayed %b, required 1", i, bus_if.in_ready);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus_if.in_ready !== (bus_if.out_ready | ~bus_if.out_valid)) begin
        errors++;
        $display("FAIL in_ready: got %b, required %b", bus_if.in_ready,
                 bus_if.out_ready | ~bus_if.out_valid);
      end
      if (holding) begin
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.Z !== held.z || bus_if.c_out !== held.c ||
            bus_if.ovf !== held.ovf || bus_if.zero !== held.zero) begin
          errors++;
          $display("FAIL stall_hold: got v=%b z=%h c=%b ovf=%b zero=%b, required v=1 z=%h c=%b ovf=%b zero=%b",
                   bus_if.out_valid, bus_if.Z, bus_if.c_out, bus_if.ovf, bus_if.zero,
                   held.z, held.c, held.ovf, held.zero);
        end
      end
      holding = 1'b0;
      if (bus_if.out_valid === 1'b1) begin
        if (bus_if.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got z=%h with no result outstanding, required none",
                     bus_if.Z);
          end else begin
            res_t e;
            e = exp_q.pop_front();
            if (bus_if.Z !== e.z || bus_if.c_out !== e.c || bus_if.ovf !== e.ovf ||
                bus_if.zero !== e.zero) begin
              errors++;
              $display("FAIL result: got z=%h c=%b ovf=%b zero=%b, required z=%h c=%b ovf=%b zero=%b",
                       bus_if.Z, bus_if.c_out, bus_if.ovf, bus_if.zero, e.z, e.c, e.ovf, e.zero);
            end
          end
        end else begin
          holding   = 1'b1;
          held.z    = bus_if.Z;
          held.c    = bus_if.c_out;
          held.ovf  = bus_if.ovf;
          held.zero = bus_if.zero;
        end
      end
    end else begin
      holding = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    time t0;
    vt[0]  = mk(32'h0000_00FF, 32'h0000_0001, 0, 0, 0, 32'h0000_0100, 0, 0, 0, 32'h0000_0100);
    vt[1]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 32'h0000_0000);
    vt[2]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h8000_0000, 0, 1, 0, 32'h7FFF_FFFF);
    vt[3]  = mk(32'h0000_0005, 32'h0000_0007, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 32'hFFFF_FFFE);
    vt[4]  = mk(32'h0000_0007, 32'h0000_0007, 0, 1, 0, 32'h0000_0000, 1, 0, 1, 32'h0000_0000);
    vt[5]  = mk(32'h1234_5678, 32'h1111_1111, 1, 0, 0, 32'h2345_678A, 0, 0, 0, 32'h2345_678A);
    vt[6]  = mk(32'h0000_000A, 32'h0000_0003, 1, 1, 0, 32'h0000_0006, 1, 0, 0, 32'h0000_0006);
    vt[7]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h7FFF_FFFF, 1, 1, 0, 32'h8000_0000);
    vt[8]  = mk(32'h8000_0000, 32'h0000_0001, 0, 1, 0, 32'h7FFF_FFFF, 1, 1, 0, 32'h7FFF_FFFF);
    vt[9]  = mk(32'h00FF_00FF, 32'h0001_0001, 0, 0, 0, 32'h0100_0100, 0, 0, 0, 32'h0100_0100);
    vt[10] = mk(32'hAAAA_AAAA, 32'h5555_5555, 1, 0, 0, 32'h0000_0000, 1, 0, 1, 32'h0000_0000);
    vt[11] = mk(32'h0000_0000, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 1, 0, 1, 32'h0000_0000);
    vt[12] = mk(32'h4000_0000, 32'h4000_0000, 0, 0, 1, 32'h8000_0000, 0, 1, 0, 32'h7FFF_FFFF);
    vt[13] = mk(32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC);
    vt[14] = mk(32'h0000_0003, 32'h0000_0004, 0, 0, 1, 32'h0000_0007, 0, 0, 0, 32'h0000_0007);

    // Operands offered while in reset must never be accepted.
    bus_if.in_valid  = 1'b1;
    bus_if.X         = 32'h1111_1111;
    bus_if.Y         = 32'h2222_2222;
    bus_if.c_in      = 1'b0;
    bus_if.sub       = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
    bus_if.sat       = 1'b0;
`endif
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.Z !== '0 || bus_if.c_out !== 1'b0 ||
        bus_if.ovf !== 1'b0 || bus_if.zero !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b z=%h c=%b ovf=%b zero=%b rdy=%b, required all 0 and rdy=1",
               bus_if.out_valid, bus_if.Z, bus_if.c_out, bus_if.ovf, bus_if.zero, bus_if.in_ready);
    end
    @(posedge clk); #1;

    // Latency of a single operand set.
    bus_if.out_ready = 1'b1;
    issue(0);
    lat = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_if.out_valid === 1'b1) break;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != NSTG) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, NSTG);
    end
    @(posedge clk); #1;
    wait_empty();

    // Back-to-back directed vectors: one accept per cycle.
    t0 = $time;
    for (int i = 1; i < NV; i++) issue(i);
    checks++;
    if (($time - t0) != (NV - 1) * 10) begin
      errors++;
      $display("FAIL throughput: got %0d cycles for %0d sets, required %0d",
               ($time - t0) / 10, NV - 1, NV - 1);
    end
    wait_empty();

    // Streaming with out_ready toggling 1,0,1,0.
    bus_if.out_ready = 1'b1;
    stream_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 10; j++) issue((j * 3 + 1) % NV);
        stream_done = 1'b1;
      end
      begin
        for (int n = 0; n < 200 && !stream_done; n++) begin
          @(posedge clk); #1;
          if (!stream_done) bus_if.out_ready = ~bus_if.out_ready;
        end
      end
    join
    bus_if.out_ready = 1'b1;
    wait_empty();

    // Reset with three sets in flight; none may surface afterwards.
    issue(5);
    issue(6);
    issue(9);
    rst = 1'b1;
    exp_q.delete();
    bus_if.in_valid = 1'b1;
    bus_if.X = vt[0].x; bus_if.Y = vt[0].y; bus_if.c_in = 1'b0; bus_if.sub = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: out_valid=%b after reset, required 0", bus_if.out_valid);
    end
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus_if.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_discard: got a result after reset, required none");
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
